// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder slice (package mips_mem_pkg).
package mips_mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } mem_state_t;

  // True when any address bit at or above the word-index width is set.
  function automatic logic addr_out_of_range(input word_t addr, input int addr_w);
    logic oor;
    oor = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i >= addr_w) oor = oor | addr[i];
    end
    return oor;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with one write port and a registered read.
// No reset on the storage so the array maps onto block RAM.
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Read-first: a write cycle returns the previous contents, which the
  // responder never forwards because writes respond with zero data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR load/store port: one request at a time,
// programmable wait states, one-cycle ready pulse. Optional range check: MEM_ERR_EN.
//
// state | meaning
// IDLE  | waiting for mem_req; captures addr/we/wdata when it rises
// WAIT  | counting down wait states on the captured request
// RESP  | array accessed on entry; mem_ready pulses on the following edge
// HOLD  | response given; waits for mem_req to drop
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  mem_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t addr_q, addr_d;
  word_t wdata_q, wdata_d;
  logic we_q, we_d;
  logic rd_q, rd_d;
  logic rerr_q, rerr_d;
  logic ready_q, ready_d;
  logic merr_q, merr_d;
  word_t rdata_q, rdata_d;

  word_t acc_addr, acc_wdata;
  logic acc_we, acc_err, enter_resp;
  logic ram_en, ram_we;
  word_t ram_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_we     = we_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          we_d      = mem_we;
          acc_addr  = mem_addr;
          acc_wdata = mem_wdata;
          acc_we    = mem_we;
          // With no wait states the array is accessed on the capture edge itself.
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: state_d = HOLD;
      HOLD: begin
        if (!mem_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ERR_EN
  assign acc_err = addr_out_of_range(acc_addr, ADDR_W);
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    rd_d   = rd_q;
    rerr_d = rerr_q;
    if (enter_resp) begin
      rd_d   = ~acc_we & ~acc_err;
      rerr_d = acc_err;
    end
    ready_d = (state_q == RESP);
    merr_d  = (state_q == RESP) & rerr_q;
    rdata_d = ((state_q == RESP) && rd_q) ? ram_rdata : '0;
  end

  // Reset on the commit edge discards the write, matching the FSM abort.
  assign ram_en = enter_resp & reset;
  assign ram_we = enter_resp & acc_we & ~acc_err & reset;

  mem_array #(.ADDR_W(ADDR_W)) u_mem_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_addr[ADDR_W-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      rerr_q  <= 1'b0;
      ready_q <= 1'b0;
      merr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      rerr_q  <= rerr_d;
      ready_q <= ready_d;
      merr_q  <= merr_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_err   = merr_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked every
// cycle against a timeline model, plus directed literal expectations.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int n_chk = 0;
  int n_err = 0;

  mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset(reset), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]), .mem_err(err[0])
  );

  mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]), .mem_err(err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int g);
    return (g == 0) ? 2 : 0;
  endfunction

  // Model: request accepted at edge t commits at edge t+WS and shows ready
  // after edge t+WS+1; afterwards a new request needs mem_req low first.
  logic [31:0] m_mem [int];
  bit          m_busy  [2];
  int          m_t     [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] c_rdata [2];
  bit          c_err   [2];
  bit          c_known [2];
  bit          e_ready [2];
  bit          e_err   [2];
  bit          e_known [2];
  logic [31:0] e_rdata [2];
  bit          e_rst;
  int          cyc = 0;

  task automatic commit(input int g);
    int key;
    bit oor;
    key = g * 4096 + int'(m_addr[g][9:0]);
    oor = (m_addr[g] >> 10) != 0;
`ifdef MEM_ERR_EN
    c_err[g] = oor;
`else
    c_err[g] = 1'b0;
`endif
    c_known[g] = 1'b1;
    c_rdata[g] = 32'h0;
    if (!c_err[g]) begin
      if (m_we[g]) m_mem[key] = m_wdata[g];
      else if (m_mem.exists(key)) c_rdata[g] = m_mem[key];
      else c_known[g] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    e_rst = !reset;
    for (int g = 0; g < 2; g++) begin
      e_ready[g] = 1'b0;
      e_err[g]   = 1'b0;
      e_rdata[g] = 32'h0;
      e_known[g] = 1'b1;
      if (!reset) m_busy[g] = 1'b0;
      else if (!m_busy[g]) begin
        if (req[g]) begin
          m_busy[g]  = 1'b1;
          m_t[g]     = cyc;
          m_we[g]    = we[g];
          m_addr[g]  = addr[g];
          m_wdata[g] = wdata[g];
          if (ws_of(g) == 0) commit(g);
        end
      end else if (cyc == m_t[g] + ws_of(g)) commit(g);
      else if (cyc == m_t[g] + ws_of(g) + 1) begin
        e_ready[g] = 1'b1;
        e_err[g]   = c_err[g];
        e_rdata[g] = c_rdata[g];
        e_known[g] = c_known[g];
      end else if (cyc > m_t[g] + ws_of(g) + 1 && !req[g]) m_busy[g] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ws%0d ready cyc%0d", ws_of(g), cyc), ready[g], e_ready[g]);
        chk($sformatf("ws%0d err cyc%0d", ws_of(g), cyc), err[g], e_err[g]);
        if ((e_ready[g] && e_known[g]) || e_rst)
          chk($sformatf("ws%0d rdata cyc%0d", ws_of(g), cyc), rdata[g], e_rdata[g]);
      end
    end
  end

  // Called at a negedge; returns at a negedge one cycle after the pulse.
  task automatic xact(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (ready[g]) break;
    end
    chk($sformatf("ws%0d handshake", ws_of(g)), ready[g], 1);
    rd = rdata[g]; er = err[g]; lat = n - 1;
    req[g] = 1'b0; we[g] = 1'b0;
    @(negedge clk);
    chk($sformatf("ws%0d pulse width", ws_of(g)), ready[g], 0);
  endtask

  logic [31:0] rd;
  logic er;
  int lat, pulses;

  initial begin
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; we[g] = 1'b0; addr[g] = 32'h0; wdata[g] = 32'h0;
    end

    // T1: reset held with a live request
    req[0] = 1'b1; req[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1 ready", ready[0], 0);
      chk("t1 err", err[0], 0);
      chk("t1 rdata", rdata[0], 0);
    end
    reset = 1'b1; req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk);

    // T2: two wait states, write then read back
    xact(0, 1'b1, 32'h5, 32'hDEADBEEF, rd, er, lat);
    chk("t2 write latency", lat, 3);
    chk("t2 write rdata", rd, 0);
    xact(0, 1'b0, 32'h5, 32'h0, rd, er, lat);
    chk("t2 read latency", lat, 3);
    chk("t2 read data", rd, 32'hDEADBEEF);

    // T3: zero wait states at the top address
    xact(1, 1'b1, 32'h3FF, 32'h12345678, rd, er, lat);
    xact(1, 1'b0, 32'h3FF, 32'h0, rd, er, lat);
    chk("t3 read latency", lat, 1);
    chk("t3 read data", rd, 32'h12345678);

    // T4: held request gives exactly one pulse; drop and raise gives another
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h5;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("t4 held pulses", pulses, 1);
    req[0] = 1'b0;
    @(negedge clk);
    req[0] = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("t4 second pulses", pulses, 1);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // T5: reset while the write is still waiting
    xact(0, 1'b1, 32'h7, 32'h11112222, rd, er, lat);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h7; wdata[0] = 32'hAAAA0000;
    @(negedge clk);
    reset = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, 32'h7, 32'h0, rd, er, lat);
    chk("t5 old data", rd, 32'h11112222);

    // T6: address just past the array
    xact(0, 1'b1, 32'h0, 32'h0BADF00D, rd, er, lat);
    xact(0, 1'b1, 32'h400, 32'h1, rd, er, lat);
`ifdef MEM_ERR_EN
    chk("t6 write err", er, 1);
`else
    chk("t6 write err", er, 0);
`endif
    xact(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
`ifdef MEM_ERR_EN
    chk("t6 array0", rd, 32'h0BADF00D);
`else
    chk("t6 array0", rd, 32'h1);
`endif
    xact(0, 1'b0, 32'h405, 32'h0, rd, er, lat);
`ifdef MEM_ERR_EN
    chk("t6 alias read", rd, 32'h0);
    chk("t6 alias err", er, 1);
`else
    chk("t6 alias read", rd, 32'hDEADBEEF);
    chk("t6 alias err", er, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
